mat_vec_seq_3: RTL and testbench
================================

Name: mat_vec_seq_3

Overview:
- Sequences one shared 3-element dot-product pipeline to compute a 3x3 matrix times 3-vector product (M·v).
- Accepts a matrix/vector pair over a valid/ready handshake and issues the three matrix rows back-to-back into the dot-product unit.
- Tracks in-flight rows with a tag shift register, gathers the three results and presents them over a valid/ready output handshake.
- Sits between the vertex/transform front end and the shared dot-product unit, which is instantiated outside this block.

Parameters:
- WIDTH, 32, bit width of every scalar element.
- DP_LATENCY, 3, cycles from operands presented on dp_x*/dp_y* to the matching result valid on dp_out; must be >= 1.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- in_valid  input  1  matrix/vector pair offered
- in_ready  output  1  block can accept a pair
- in_mat  input  9*WIDTH  element m[r][c] at bits [(3r+c)*WIDTH +: WIDTH], signed
- in_vec  input  3*WIDTH  element v[i] at bits [i*WIDTH +: WIDTH], signed
- dp_x0, dp_x1, dp_x2  output  WIDTH each  registered row operands to the dot-product unit
- dp_y0, dp_y1, dp_y2  output  WIDTH each  registered vector operands
- dp_issue  output  1  high in cycles where the dp_* operands are meaningful
- dp_out  input  WIDTH  dot-product result
- out_valid  output  1  result vector valid
- out_ready  input  1  consumer accepts the result
- out_vec  output  3*WIDTH  result r at bits [r*WIDTH +: WIDTH]
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clocking: single clock clk_in. rst_in is synchronous and active-high.
- Reset: state becomes IDLE. in_ready=1, out_valid=0, dp_issue=0, busy=0. All dp_x*/dp_y* and out_vec are 0. The in-flight tag pipeline is cleared.
- States:
  - IDLE: in_ready=1. A handshake (in_valid && in_ready) captures in_mat/in_vec and moves to ISSUE.
  - ISSUE: lasts exactly 3 cycles. Cycle k (k=0,1,2) drives row k onto dp_x0..2 and in_vec onto dp_y0..2, with dp_issue=1. Moves to DRAIN after row 2.
  - DRAIN: waits until the row-2 result has been captured, then moves to DONE.
  - DONE: out_valid=1. out_vec is held stable until out_ready is high; on that handshake the block returns to IDLE.
- Timing (handshake in cycle 0):
  - Row r is presented in cycle 1+r.
  - Its result is sampled from dp_out in cycle 1+r+DP_LATENCY.
  - out_valid first rises in cycle DP_LATENCY+4, i.e. cycle 7 at the default.
  - With out_ready held high, the next input is accepted in cycle DP_LATENCY+5.
- Result capture: a DP_LATENCY-deep shift register carries {valid, row[1:0]} alongside each issued row. A captured result goes to slot row; capture never relies on free-running counters.
- Operand lines: outside ISSUE, dp_x*/dp_y* are driven to 0 and dp_issue=0.
- Input blocking: in_ready=0 in ISSUE, DRAIN and DONE. in_valid in those states is ignored; no data is lost because the source must hold it.
- Output backpressure: out_vec and out_valid must not change while out_valid && !out_ready.
- Arithmetic: results are stored exactly as received; dp_out is not reinterpreted. Fixed-point or integer mode belongs to the dot-product unit, and this block is agnostic to it.
- Reset mid-operation: any in-flight rows are discarded. Results arriving from the external pipeline after reset are ignored, because the tag pipeline is cleared. out_valid stays 0 until a new complete transform finishes.
- Boundary cases:
  - in_valid arriving in the same cycle as the DONE→IDLE handshake is not accepted; it is accepted in the following IDLE cycle.
  - DP_LATENCY=1: DRAIN lasts 1 cycle.

Optional Feature:
- Macro: MAT_VEC_BIAS_EN.
- When defined:
  - Adds input port in_bias [3*WIDTH-1:0], captured at the input handshake with the same packing as in_vec.
  - Each captured result becomes dp_out + bias[r], with the sum wrapping mod 2^WIDTH, so the block computes the affine transform M·v + t.
  - Latency is unchanged.
- When undefined: the in_bias port does not exist and results equal dp_out.

Test Plan:
- Bench uses a behavioural dot-product model with DP_LATENCY=3.
- Identity: M=identity, v=(5,-7,9), out_ready=1 → out_valid rises exactly 7 cycles after the handshake cycle; out_vec=(5,-7,9); dp_issue high for exactly 3 consecutive cycles.
- General: M rows (1,2,3),(4,5,6),(-1,0,2), v=(2,1,-1) → out_vec=(1,7,-4); next handshake accepted in cycle 8.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_vec stable, in_ready=0, busy=1; handshake in cycle 12 → IDLE in cycle 13.
- Wrap: WIDTH=8, row 0 = (100,100,100), v=(1,1,1) → out_vec[0]=44 (300 mod 256).
- Reset mid-op: assert rst_in for 1 cycle at cycle 5 → out_valid stays 0 for the following 10 cycles with no new input; in_ready=1 the cycle after reset.
- Bias (MAT_VEC_BIAS_EN defined): identity M, v=(5,-7,9), in_bias=(1,2,3) → out_vec=(6,-5,12), same latency.

Source files
------------

// File: rtl/mat_vec_seq_3.sv
// rtl/mat_vec_seq_3.sv - 3x3 matrix times 3-vector sequencer around one shared dot-product unit
// Optional affine bias term enabled by defining MAT_VEC_BIAS_EN.
module mat_vec_seq_3 #(
    parameter int WIDTH      = 32,
    parameter int DP_LATENCY = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [9*WIDTH-1:0]   in_mat,
    input  logic [3*WIDTH-1:0]   in_vec,
`ifdef MAT_VEC_BIAS_EN
    input  logic [3*WIDTH-1:0]   in_bias,
`endif
    output logic [WIDTH-1:0]     dp_x0,
    output logic [WIDTH-1:0]     dp_x1,
    output logic [WIDTH-1:0]     dp_x2,
    output logic [WIDTH-1:0]     dp_y0,
    output logic [WIDTH-1:0]     dp_y1,
    output logic [WIDTH-1:0]     dp_y2,
    output logic                 dp_issue,
    input  logic [WIDTH-1:0]     dp_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*WIDTH-1:0]   out_vec,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [9*WIDTH-1:0]    r_mat;
    logic [3*WIDTH-1:0]    r_vec;
    logic [WIDTH-1:0]      r_dp_x0, r_dp_x1, r_dp_x2;
    logic [WIDTH-1:0]      r_dp_y0, r_dp_y1, r_dp_y2;
    logic                  r_dp_issue;
    logic [1:0]            r_dp_row;
    logic                  r_tag_v   [DP_LATENCY];
    logic [1:0]            r_tag_row [DP_LATENCY];
    logic [WIDTH-1:0]      r_res0, r_res1, r_res2;

    logic [9*WIDTH-1:0]    w_src_mat;
    logic [3*WIDTH-1:0]    w_src_vec;
    logic [1:0]            w_sel_row;
    logic [3*WIDTH-1:0]    w_row;
    logic                  w_issue_now;
    logic                  w_cap_v;
    logic [1:0]            w_cap_row;
    logic [WIDTH-1:0]      w_result;

    assign w_cap_v   = r_tag_v[DP_LATENCY-1];
    assign w_cap_row = r_tag_row[DP_LATENCY-1];

    // Row 0 is loaded straight from the input bus on the accepting edge so it appears one cycle later.
    always_comb begin
        w_src_mat   = (r_state == S_IDLE) ? in_mat : r_mat;
        w_src_vec   = (r_state == S_IDLE) ? in_vec : r_vec;
        w_sel_row   = (r_state == S_IDLE) ? 2'd0 : r_dp_row + 2'd1;
        w_issue_now = ((r_state == S_IDLE) && in_valid) ||
                      ((r_state == S_ISSUE) && (r_dp_row != 2'd2));
        case (w_sel_row)
            2'd1:    w_row = w_src_mat[3*WIDTH +: 3*WIDTH];
            2'd2:    w_row = w_src_mat[6*WIDTH +: 3*WIDTH];
            default: w_row = w_src_mat[0 +: 3*WIDTH];
        endcase
    end

`ifdef MAT_VEC_BIAS_EN
    logic [3*WIDTH-1:0]    r_bias;
    logic [WIDTH-1:0]      w_bias;

    always_comb begin
        case (w_cap_row)
            2'd1:    w_bias = r_bias[WIDTH +: WIDTH];
            2'd2:    w_bias = r_bias[2*WIDTH +: WIDTH];
            default: w_bias = r_bias[0 +: WIDTH];
        endcase
        w_result = dp_out + w_bias;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_bias <= '0;
        end else if ((r_state == S_IDLE) && in_valid) begin
            r_bias <= in_bias;
        end
    end
`else
    assign w_result = dp_out;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_mat      <= '0;
            r_vec      <= '0;
            r_dp_x0    <= '0;
            r_dp_x1    <= '0;
            r_dp_x2    <= '0;
            r_dp_y0    <= '0;
            r_dp_y1    <= '0;
            r_dp_y2    <= '0;
            r_dp_issue <= 1'b0;
            r_dp_row   <= 2'd0;
            r_res0     <= '0;
            r_res1     <= '0;
            r_res2     <= '0;
            for (int i = 0; i < DP_LATENCY; i++) begin
                r_tag_v[i]   <= 1'b0;
                r_tag_row[i] <= 2'd0;
            end
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && in_valid) begin
                r_mat <= in_mat;
                r_vec <= in_vec;
            end
            if (w_issue_now) begin
                r_dp_x0    <= w_row[0 +: WIDTH];
                r_dp_x1    <= w_row[WIDTH +: WIDTH];
                r_dp_x2    <= w_row[2*WIDTH +: WIDTH];
                r_dp_y0    <= w_src_vec[0 +: WIDTH];
                r_dp_y1    <= w_src_vec[WIDTH +: WIDTH];
                r_dp_y2    <= w_src_vec[2*WIDTH +: WIDTH];
                r_dp_issue <= 1'b1;
                r_dp_row   <= w_sel_row;
            end else begin
                r_dp_x0    <= '0;
                r_dp_x1    <= '0;
                r_dp_x2    <= '0;
                r_dp_y0    <= '0;
                r_dp_y1    <= '0;
                r_dp_y2    <= '0;
                r_dp_issue <= 1'b0;
                r_dp_row   <= 2'd0;
            end
            // Tags travel with the operands, so each result lands in its own slot.
            r_tag_v[0]   <= r_dp_issue;
            r_tag_row[0] <= r_dp_row;
            for (int i = 1; i < DP_LATENCY; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_row[i] <= r_tag_row[i-1];
            end
            if (w_cap_v) begin
                case (w_cap_row)
                    2'd0:    r_res0 <= w_result;
                    2'd1:    r_res1 <= w_result;
                    2'd2:    r_res2 <= w_result;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (r_dp_row == 2'd2) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_cap_v && (w_cap_row == 2'd2)) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign dp_x0    = r_dp_x0;
    assign dp_x1    = r_dp_x1;
    assign dp_x2    = r_dp_x2;
    assign dp_y0    = r_dp_y0;
    assign dp_y1    = r_dp_y1;
    assign dp_y2    = r_dp_y2;
    assign dp_issue = r_dp_issue;
    assign out_vec  = {r_res2, r_res1, r_res0};

endmodule

// File: tb/tb_mat_vec_seq_3.sv
// tb/tb_mat_vec_seq_3.sv - scoreboard bench for mat_vec_seq_3 with behavioural dot-product models
module tb_mat_vec_seq_3;

    localparam int W = 32;
`ifdef MAT_VEC_BIAS_EN
    localparam bit BIAS_ON = 1'b1;
`else
    localparam bit BIAS_ON = 1'b0;
`endif

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [9*W-1:0] in_mat = '0;
    logic [3*W-1:0] in_vec = '0;
    logic [3*W-1:0] in_bias = '0;
    logic [W-1:0]   dp_x0, dp_x1, dp_x2, dp_y0, dp_y1, dp_y2, dp_out;
    logic           dp_issue;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [3*W-1:0] out_vec;
    logic           busy;

    logic           b_in_valid = 1'b0;
    logic           b_in_ready;
    logic [71:0]    b_in_mat = '0;
    logic [23:0]    b_in_vec = '0;
    logic [7:0]     b_x0, b_x1, b_x2, b_y0, b_y1, b_y2, b_out;
    logic           b_issue, b_out_valid, b_busy;
    logic [23:0]    b_out_vec;

    always #5 clk_in = ~clk_in;

    mat_vec_seq_3 #(.WIDTH(W), .DP_LATENCY(3)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready),
        .in_mat(in_mat), .in_vec(in_vec),
`ifdef MAT_VEC_BIAS_EN
        .in_bias(in_bias),
`endif
        .dp_x0(dp_x0), .dp_x1(dp_x1), .dp_x2(dp_x2),
        .dp_y0(dp_y0), .dp_y1(dp_y1), .dp_y2(dp_y2),
        .dp_issue(dp_issue), .dp_out(dp_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .busy(busy)
    );

    mat_vec_seq_3 #(.WIDTH(8), .DP_LATENCY(3)) u_dut8 (
        .clk_in(clk_in), .rst_in(rst_in), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mat(b_in_mat), .in_vec(b_in_vec),
`ifdef MAT_VEC_BIAS_EN
        .in_bias(24'd0),
`endif
        .dp_x0(b_x0), .dp_x1(b_x1), .dp_x2(b_x2),
        .dp_y0(b_y0), .dp_y1(b_y1), .dp_y2(b_y2),
        .dp_issue(b_issue), .dp_out(b_out),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_vec(b_out_vec), .busy(b_busy)
    );

    // Three-stage dot-product models, results truncated to the element width.
    logic [W-1:0] p0, p1, p2;
    logic [7:0]   q0, q1, q2;
    always @(posedge clk_in) begin
        p0 <= dp_x0 * dp_y0 + dp_x1 * dp_y1 + dp_x2 * dp_y2;
        p1 <= p0;
        p2 <= p1;
        q0 <= b_x0 * b_y0 + b_x1 * b_y1 + b_x2 * b_y2;
        q1 <= q0;
        q2 <= q1;
    end
    assign dp_out = p2;
    assign b_out  = q2;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] mk3(input int a, input int b, input int c);
        mk3 = {c[31:0], b[31:0], a[31:0]};
    endfunction

    function automatic logic [95:0] model(input logic [9*W-1:0] m, input logic [3*W-1:0] v,
                                          input logic [3*W-1:0] b);
        logic [W-1:0] acc;
        model = '0;
        for (int r = 0; r < 3; r++) begin
            acc = '0;
            for (int c = 0; c < 3; c++) acc = acc + m[(3*r+c)*W +: W] * v[c*W +: W];
            if (BIAS_ON) acc = acc + b[r*W +: W];
            model[r*W +: W] = acc;
        end
    endfunction

    logic [95:0] sb_q[$];

    // Output monitor: scoreboard pops, backpressure stability, dp_issue profile.
    logic        prev_hold = 1'b0;
    logic [95:0] prev_vec;
    logic        prev_issue = 1'b0;
    int          issue_cnt = 0;
    int          issue_rise = 0;
    int          first_issue = 0;
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (prev_hold) begin
                check("hold_valid", {95'd0, out_valid}, 96'd1);
                check("hold_vec", out_vec, prev_vec);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) check("sb_empty", 96'd0, 96'd1);
                else check("sb_vec", out_vec, sb_q.pop_front());
            end
            if (dp_issue) issue_cnt++;
            if (dp_issue && !prev_issue) begin
                issue_rise++;
                first_issue = cyc;
            end
        end
        prev_hold  = out_valid && !out_ready;
        prev_vec   = out_vec;
        prev_issue = dp_issue;
    end

    int t_hs;

    // Call just after a posedge; returns just after the posedge following the accepting cycle.
    task automatic send(input logic [9*W-1:0] m, input logic [3*W-1:0] v, input logic [3*W-1:0] b);
        bit ok;
        ok = 1'b0;
        in_mat   = m;
        in_vec   = v;
        in_bias  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk_in);
            if (in_ready) begin
                ok = 1'b1;
                t_hs = cyc;
                sb_q.push_back(model(m, v, b));
            end
        end
        if (!ok) check("send_timeout", 96'd0, 96'd1);
        @(posedge clk_in); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(output int lat);
        bit ok;
        ok = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk_in);
            if (out_valid) begin
                ok = 1'b1;
                lat = cyc - t_hs;
            end
        end
        if (!ok) check("out_timeout", 96'd0, 96'd1);
    endtask

    logic [9*W-1:0] m_id, m_gen;
    logic [3*W-1:0] v_id, v_gen;
    logic [95:0]    held;
    int             lat, t1, t2;
    bit             seen;

    initial begin
        m_id  = {mk3(0, 0, 1), mk3(0, 1, 0), mk3(1, 0, 0)};
        v_id  = mk3(5, -7, 9);
        m_gen = {mk3(-1, 0, 2), mk3(4, 5, 6), mk3(1, 2, 3)};
        v_gen = mk3(2, 1, -1);

        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        check("rst_in_ready", {95'd0, in_ready}, 96'd1);
        check("rst_out_valid", {95'd0, out_valid}, 96'd0);
        check("rst_dp_issue", {95'd0, dp_issue}, 96'd0);
        check("rst_busy", {95'd0, busy}, 96'd0);
        check("rst_out_vec", out_vec, 96'd0);
        check("rst_dp_ops", {dp_x0, dp_x1, dp_y2}, 96'd0);

        // Identity: latency, result, dp_issue profile
        @(posedge clk_in); #1;
        send(m_id, v_id, '0);
        wait_out_valid(lat);
        check("id_latency", lat, 96'd7);
        check("id_vec", out_vec, mk3(5, -7, 9));
        check("id_issue_cnt", issue_cnt, 96'd3);
        check("id_issue_rise", issue_rise, 96'd1);
        check("id_issue_first", first_issue - t_hs, 96'd1);

        // General followed immediately by a held request: second accept 8 cycles later
        @(posedge clk_in); #1;
        send(m_gen, v_gen, '0);
        t1 = t_hs;
        check("gen_expected", model(m_gen, v_gen, '0), mk3(1, 7, -4));
        send(m_gen, mk3(3, -2, 4), '0);
        t2 = t_hs;
        check("gen_next_accept", t2 - t1, 96'd8);

        // Backpressure on the second transform
        out_ready = 1'b0;
        wait_out_valid(lat);
        check("bp_latency", lat, 96'd7);
        held = out_vec;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk_in);
            check("bp_in_ready", {95'd0, in_ready}, 96'd0);
            check("bp_busy", {95'd0, busy}, 96'd1);
            check("bp_vec", out_vec, held);
        end
        @(posedge clk_in); #1;
        out_ready = 1'b1;
        @(negedge clk_in);
        check("bp_hs_cycle", cyc - t2, 96'd12);
        check("bp_hs_valid", {95'd0, out_valid}, 96'd1);
        @(negedge clk_in);
        check("bp_idle_busy", {95'd0, busy}, 96'd0);
        check("bp_idle_ready", {95'd0, in_ready}, 96'd1);

        // Reset mid-operation at cycle 5 after the handshake
        @(posedge clk_in); #1;
        send(m_gen, v_gen, '0);
        for (int i = 0; i < 20 && cyc != t_hs + 5; i++) begin
            @(posedge clk_in); #1;
        end
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk_in);
        check("rmid_in_ready", {95'd0, in_ready}, 96'd1);
        check("rmid_busy", {95'd0, busy}, 96'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (out_valid) seen = 1'b1;
        end
        check("rmid_no_valid", {95'd0, seen}, 96'd0);

        // Identity with bias (bias is ignored when the feature is compiled out)
        @(posedge clk_in); #1;
        send(m_id, v_id, mk3(1, 2, 3));
        wait_out_valid(lat);
        check("bias_latency", lat, 96'd7);
        check("bias_vec", out_vec, BIAS_ON ? mk3(6, -5, 12) : mk3(5, -7, 9));

        // 8-bit wrap on the narrow instance
        @(posedge clk_in); #1;
        b_in_mat   = {48'd0, 8'd100, 8'd100, 8'd100};
        b_in_vec   = {8'd1, 8'd1, 8'd1};
        b_in_valid = 1'b1;
        @(posedge clk_in); #1;
        b_in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_in);
            if (b_out_valid) seen = 1'b1;
        end
        check("wrap_seen", {95'd0, seen}, 96'd1);
        check("wrap_vec", {72'd0, b_out_vec}, {72'd0, 8'd0, 8'd0, 8'd44});

        repeat (4) @(negedge clk_in);
        check("sb_drained", sb_q.size(), 96'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
